// File: rtl/wb_interconnect.sv
// Pipelined Wishbone interconnect: NUM_CTRL controllers share one bus (slot or
// round-robin ownership), decoded to NUM_PERIPH peripherals, acks routed in order.
module wb_interconnect #(
    parameter int NUM_CTRL = 3,
    parameter int NUM_PERIPH = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int MODE = 0,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255,
    parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_BASE = '0,
    parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_MASK = '0,
    localparam int OW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
    input  logic                         wb_clock_i,
    input  logic                         wb_reset_ni,
    input  logic [NUM_CTRL-1:0]          slot_en_i,
    input  logic [NUM_CTRL*ADDR_W-1:0]   ctrl_addr_i,
    input  logic [NUM_CTRL*DATA_W-1:0]   ctrl_data_i,
    input  logic [NUM_CTRL-1:0]          ctrl_we_i,
    input  logic [NUM_CTRL-1:0]          ctrl_cycle_i,
    input  logic [NUM_CTRL-1:0]          ctrl_strobe_i,
    output logic [DATA_W-1:0]            ctrl_data_o,
    output logic [NUM_CTRL-1:0]          ctrl_stall_o,
    output logic [NUM_CTRL-1:0]          ctrl_ack_o,
    output logic [NUM_CTRL-1:0]          ctrl_err_o,
    output logic [ADDR_W-1:0]            periph_addr_o,
    output logic [DATA_W-1:0]            periph_data_o,
    output logic                         periph_we_o,
    output logic                         periph_cycle_o,
    output logic [NUM_PERIPH-1:0]        periph_strobe_o,
    input  logic [NUM_PERIPH*DATA_W-1:0] periph_data_i,
    input  logic [NUM_PERIPH-1:0]        periph_stall_i,
    input  logic [NUM_PERIPH-1:0]        periph_ack_i,
    output logic [OW-1:0]                owner_o,
    output logic                         busy_o
);

    localparam int SW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] sel;
    } ent_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    ent_t          fifo_q [MAX_OUT];
    ent_t          fifo_d [MAX_OUT];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          resp_q, resp_d;

    logic [ADDR_W-1:0] own_addr;
    logic              hit;
    logic [SW-1:0]     sel;
    ent_t              head;
    logic              empty, full;
    logic              fwd_ok, fwd, own_stall, accept;
    logic              pop_ack, pop_err, pop, timeout;
    logic              grant_found;
    logic [OW-1:0]     grant_idx;
    int                rr_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign own_addr      = ctrl_addr_i[owner_q*ADDR_W +: ADDR_W];
    assign periph_addr_o = own_addr;
    assign periph_data_o = ctrl_data_i[owner_q*DATA_W +: DATA_W];
    assign periph_we_o   = ctrl_we_i[owner_q];
    assign head          = fifo_q[rd_q];
    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == CW'(MAX_OUT));
    assign pop           = pop_ack || pop_err;
    assign ctrl_data_o   = periph_data_i[head.sel*DATA_W +: DATA_W];
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != IDLE);

    // Descending scan so the lowest-index matching peripheral wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int p = NUM_PERIPH - 1; p >= 0; p--) begin
            if ((own_addr & PERIPH_MASK[p*ADDR_W +: ADDR_W]) == PERIPH_BASE[p*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                sel = SW'(p);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        fifo_d  = fifo_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        resp_d  = resp_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        fwd_ok    = 1'b0;
        fwd       = 1'b0;
        own_stall = 1'b1;
        accept    = 1'b0;
        pop_ack   = 1'b0;
        pop_err   = 1'b0;
        timeout   = 1'b0;
        ctrl_stall_o    = '1;
        ctrl_ack_o      = '0;
        ctrl_err_o      = '0;
        periph_cycle_o  = 1'b0;
        periph_strobe_o = '0;

        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (MODE == 0) begin
                        if (!grant_found && ctrl_cycle_i[i] && slot_en_i[i]) begin
                            grant_found = 1'b1;
                            grant_idx   = OW'(i);
                        end
                    end else begin
                        rr_idx = int'(rr_q) + i;
                        if (rr_idx >= NUM_CTRL) rr_idx = rr_idx - NUM_CTRL;
                        if (!grant_found && ctrl_cycle_i[rr_idx]) begin
                            grant_found = 1'b1;
                            grant_idx   = OW'(rr_idx);
                        end
                    end
                end
                if (grant_found) begin
                    owner_d = grant_idx;
                    state_d = OWNED;
                end
            end

            OWNED: begin
                periph_cycle_o = 1'b1;
                if (!ctrl_cycle_i[owner_q]) begin
                    // Owner abandoned the cycle: anything still in flight is dropped.
                    state_d = IDLE;
                    rd_d    = wr_q;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    resp_d  = 1'b0;
                    rr_d    = (owner_q == OW'(NUM_CTRL - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    fwd_ok    = (MODE == 1) || slot_en_i[owner_q];
                    fwd       = ctrl_strobe_i[owner_q] && fwd_ok;
                    own_stall = !fwd_ok || full || (hit && periph_stall_i[sel]);
                    accept    = ctrl_strobe_i[owner_q] && !own_stall;
                    periph_strobe_o[sel]  = fwd && !full && hit;
                    ctrl_stall_o[owner_q] = own_stall;

                    pop_ack = !empty && head.hit && periph_ack_i[head.sel];
                    pop_err = !empty && !head.hit && resp_q;
                    timeout = (TIMEOUT != 0) && !empty && !pop_ack && !pop_err
                              && (tmr_q == TW'(TIMEOUT - 1));
                    ctrl_ack_o[owner_q] = pop_ack;
                    ctrl_err_o[owner_q] = pop_err || timeout;

                    if (accept) fifo_d[wr_q] = '{hit: hit, sel: sel};

                    if (timeout) begin
                        // Flush, but keep a strobe accepted in this same cycle.
                        rd_d   = wr_q;
                        wr_d   = accept ? ptr_inc(wr_q) : wr_q;
                        cnt_d  = accept ? CW'(1) : '0;
                        tmr_d  = '0;
                        resp_d = 1'b0;
                    end else begin
                        if (accept) wr_d = ptr_inc(wr_q);
                        if (pop) rd_d = ptr_inc(rd_q);
                        if (accept && !pop) cnt_d = cnt_q + 1'b1;
                        else if (!accept && pop) cnt_d = cnt_q - 1'b1;
                        tmr_d  = (pop || empty || (TIMEOUT == 0)) ? '0 : tmr_q + 1'b1;
                        resp_d = !empty && !head.hit && !resp_q;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            resp_q  <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            resp_q  <= resp_d;
            fifo_q  <= fifo_d;
        end
    end

`ifndef SYNTHESIS
    logic [NUM_CTRL-1:0] owner_oh;
    assign owner_oh = NUM_CTRL'(1) << owner_q;

    a_strobe_onehot: assert property (@(posedge wb_clock_i) disable iff (!wb_reset_ni)
        $onehot0(periph_strobe_o));
    a_ack_err_excl: assert property (@(posedge wb_clock_i) disable iff (!wb_reset_ni)
        (ctrl_ack_o & ctrl_err_o) == '0);
    a_resp_owner_only: assert property (@(posedge wb_clock_i) disable iff (!wb_reset_ni)
        ((ctrl_ack_o | ctrl_err_o) & ~owner_oh) == '0);
`endif

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench: a 2-controller slot-mode instance and a 3-controller
// round-robin instance with an 8-cycle timeout, both mapped 0x8xxx / 0x9xxx.
module tb_wb_interconnect;

    localparam logic [31:0] P_BASE = {16'h9000, 16'h8000};
    localparam logic [31:0] P_MASK = {16'hF000, 16'hF000};

    logic clk;
    logic rst_n;

    // Slot-mode instance
    logic [1:0]  s_slot, s_we, s_cyc, s_stb, s_stall, s_ack, s_err, s_pstb, s_pstall, s_pack;
    logic [31:0] s_addr;
    logic [15:0] s_wdat, s_paddr, s_pdi;
    logic [7:0]  s_cdo, s_pdo;
    logic        s_pwe, s_pcyc, s_busy;
    logic [0:0]  s_owner;

    // Round-robin instance
    logic [2:0]  r_slot, r_we, r_cyc, r_stb, r_stall, r_ack, r_err;
    logic [1:0]  r_pstb, r_pstall, r_pack, r_owner;
    logic [47:0] r_addr;
    logic [23:0] r_wdat;
    logic [15:0] r_paddr, r_pdi;
    logic [7:0]  r_cdo, r_pdo;
    logic        r_pwe, r_pcyc, r_busy;

    int   n_vec;
    int   n_bad;
    int   nacc;
    int   nack;
    logic ack_now;
    logic exp_stall;

    wb_interconnect #(
        .NUM_CTRL(2), .NUM_PERIPH(2), .ADDR_W(16), .DATA_W(8), .MODE(0),
        .MAX_OUT(4), .TIMEOUT(255), .PERIPH_BASE(P_BASE), .PERIPH_MASK(P_MASK)
    ) u_slot (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .slot_en_i(s_slot),
        .ctrl_addr_i(s_addr), .ctrl_data_i(s_wdat), .ctrl_we_i(s_we),
        .ctrl_cycle_i(s_cyc), .ctrl_strobe_i(s_stb), .ctrl_data_o(s_cdo),
        .ctrl_stall_o(s_stall), .ctrl_ack_o(s_ack), .ctrl_err_o(s_err),
        .periph_addr_o(s_paddr), .periph_data_o(s_pdo), .periph_we_o(s_pwe),
        .periph_cycle_o(s_pcyc), .periph_strobe_o(s_pstb), .periph_data_i(s_pdi),
        .periph_stall_i(s_pstall), .periph_ack_i(s_pack), .owner_o(s_owner),
        .busy_o(s_busy)
    );

    wb_interconnect #(
        .NUM_CTRL(3), .NUM_PERIPH(2), .ADDR_W(16), .DATA_W(8), .MODE(1),
        .MAX_OUT(4), .TIMEOUT(8), .PERIPH_BASE(P_BASE), .PERIPH_MASK(P_MASK)
    ) u_rr (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .slot_en_i(r_slot),
        .ctrl_addr_i(r_addr), .ctrl_data_i(r_wdat), .ctrl_we_i(r_we),
        .ctrl_cycle_i(r_cyc), .ctrl_strobe_i(r_stb), .ctrl_data_o(r_cdo),
        .ctrl_stall_o(r_stall), .ctrl_ack_o(r_ack), .ctrl_err_o(r_err),
        .periph_addr_o(r_paddr), .periph_data_o(r_pdo), .periph_we_o(r_pwe),
        .periph_cycle_o(r_pcyc), .periph_strobe_o(r_pstb), .periph_data_i(r_pdi),
        .periph_stall_i(r_pstall), .periph_ack_i(r_pack), .owner_o(r_owner),
        .busy_o(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Enters one cycle after the grant edge for controller idx.
    task automatic rr_access(input int idx, input logic [15:0] addr,
                             input logic [1:0] ps, input logic [7:0] dat);
        logic [2:0] es;
        logic [2:0] eack;
        logic [7:0] wd;
        es       = 3'b111;
        es[idx]  = 1'b0;
        eack     = 3'b000;
        eack[idx] = 1'b1;
        wd       = ~dat;
        r_stb[idx] = 1'b1;
        r_addr[idx*16 +: 16] = addr;
        r_wdat[idx*8 +: 8]   = wd;
        mid();
        chk("rr_owner", r_owner, idx);
        chk("rr_busy", r_busy, 1);
        chk("rr_pstb", r_pstb, ps);
        chk("rr_stall", r_stall, es);
        chk("rr_paddr", r_paddr, addr);
        chk("rr_wdata", r_pdo, wd);
        nxt();
        r_stb[idx] = 1'b0;
        r_pack = ps;
        r_pdi  = {dat, dat};
        mid();
        chk("rr_ack", r_ack, eack);
        chk("rr_rdata", r_cdo, dat);
        nxt();
        r_pack = 2'b00;
        r_cyc[idx] = 1'b0;
        mid();
        chk("rr_ack_off", r_ack, 0);
        nxt();
        r_cyc[idx] = 1'b1;
        mid();
        chk("rr_idle_gap", r_busy, 0);
        nxt();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        s_slot = '0; s_we = '0; s_cyc = '0; s_stb = '0; s_addr = '0; s_wdat = '0;
        s_pdi = '0; s_pstall = '0; s_pack = '0;
        r_slot = '0; r_we = '0; r_cyc = '0; r_stb = '0; r_addr = '0; r_wdat = '0;
        r_pdi = '0; r_pstall = '0; r_pack = '0;

        // Reset values
        repeat (2) @(posedge clk);
        mid();
        chk("rst_s_stall", s_stall, 2'b11);
        chk("rst_s_pcyc", s_pcyc, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_r_stall", r_stall, 3'b111);
        chk("rst_r_ackerr", {r_ack, r_err}, 0);
        chk("rst_r_pstb", r_pstb, 0);
        chk("rst_r_owner", r_owner, 0);
        nxt();
        rst_n = 1'b1;

        // Slot mode: strobe only forwarded in ctrl0's slot, ctrl1 never served
        s_cyc = 2'b11; s_stb = 2'b11; s_addr = {16'h9000, 16'h8000};
        mid();
        chk("slot_no_grant", s_busy, 0);
        chk("slot_stall0", s_stall, 2'b11);
        nxt();
        s_slot = 2'b01;
        mid();
        chk("slot_grant_lat", s_busy, 0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            s_slot = 2'b00;
            mid();
            chk("slot_busy", s_busy, 1);
            chk("slot_owner", s_owner, 0);
            chk("slot_pcyc", s_pcyc, 1);
            chk("slot_pstb_off", s_pstb, 2'b00);
            chk("slot_stall_off", s_stall, 2'b11);
            nxt();
        end
        s_slot = 2'b01;
        mid();
        chk("slot_pstb_on", s_pstb, 2'b01);
        chk("slot_stall_on", s_stall, 2'b10);
        chk("slot_paddr", s_paddr, 16'h8000);
        nxt();
        s_slot = 2'b00; s_stb = 2'b10; s_pack = 2'b01; s_pdi = 16'h00A5;
        mid();
        chk("slot_ack", s_ack, 2'b01);
        chk("slot_rdata", s_cdo, 8'hA5);
        chk("slot_stall_c1", s_stall, 2'b11);
        nxt();
        s_pack = 2'b00; s_cyc = 2'b10;
        mid();
        chk("slot_ack_off", s_ack, 2'b00);
        nxt();
        mid();
        chk("slot_release", s_busy, 0);
        chk("slot_stall_end", s_stall, 2'b11);
        nxt();
        s_cyc = 2'b00; s_stb = 2'b00;

        // Round-robin: grant order 0,1,2,0 with an idle gap between owners
        r_cyc = 3'b111;
        mid();
        chk("rr_first_idle", r_busy, 0);
        nxt();
        rr_access(0, 16'h8010, 2'b01, 8'h11);
        rr_access(1, 16'h9020, 2'b10, 8'h22);
        rr_access(2, 16'h8030, 2'b01, 8'h33);
        rr_access(0, 16'h9040, 2'b10, 8'h44);
        r_cyc = 3'b000;
        mid();
        chk("rr_wrap_owner", r_owner, 1);
        nxt();
        r_cyc = 3'b100;
        mid();
        chk("rr_idle2", r_busy, 0);
        nxt();

        // Burst of 6 to periph 1, acks 4 cycles after each accept; 5th stalls on full
        nacc = 0;
        nack = 0;
        for (int t = 0; t <= 10; t++) begin
            r_stb[2] = (nacc < 6);
            r_addr[32 +: 16] = 16'h9000 + 16'(nacc);
            ack_now = (t == 4) || (t == 5) || (t == 6) || (t == 7) || (t == 9) || (t == 10);
            r_pack = ack_now ? 2'b10 : 2'b00;
            r_pdi[15:8] = 8'hB0 + 8'(nack);
            exp_stall = (t == 4);
            mid();
            chk("burst_stall", r_stall[2], exp_stall);
            chk("burst_pstb", r_pstb, (r_stb[2] && !exp_stall) ? 2'b10 : 2'b00);
            chk("burst_ack", r_ack, ack_now ? 3'b100 : 3'b000);
            if (ack_now) chk("burst_rdata", r_cdo, 8'hB0 + 8'(nack));
            if (r_stb[2] && !exp_stall) nacc++;
            if (ack_now) nack++;
            nxt();
        end
        r_stb = 3'b000;
        r_pack = 2'b00;

        // Unmapped access answered with an error, then a mapped access succeeds
        r_stb[2] = 1'b1;
        r_addr[32 +: 16] = 16'hE800;
        mid();
        chk("unmap_pstb", r_pstb, 2'b00);
        chk("unmap_stall", r_stall[2], 0);
        nxt();
        r_stb[2] = 1'b0;
        mid();
        chk("unmap_err_early", r_err, 3'b000);
        nxt();
        mid();
        chk("unmap_err", r_err, 3'b100);
        chk("unmap_no_ack", r_ack, 3'b000);
        nxt();
        r_stb[2] = 1'b1;
        r_addr[32 +: 16] = 16'h8020;
        mid();
        chk("unmap_err_pulse", r_err, 3'b000);
        chk("after_unmap_pstb", r_pstb, 2'b01);
        nxt();
        r_stb[2] = 1'b0;
        r_pack = 2'b01;
        r_pdi = 16'h005A;
        mid();
        chk("after_unmap_ack", r_ack, 3'b100);
        chk("after_unmap_rdata", r_cdo, 8'h5A);
        nxt();
        r_pack = 2'b00;

        // Timeout: no ack for 8 cycles
        r_stb[2] = 1'b1;
        r_addr[32 +: 16] = 16'h8030;
        mid();
        chk("to_pstb", r_pstb, 2'b01);
        nxt();
        r_stb[2] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            mid();
            chk("to_err", r_err, (i == 8) ? 3'b100 : 3'b000);
            nxt();
        end
        r_stb[2] = 1'b1;
        r_addr[32 +: 16] = 16'h8040;
        mid();
        chk("to_next_pstb", r_pstb, 2'b01);
        chk("to_next_stall", r_stall[2], 0);
        chk("to_err_pulse", r_err, 3'b000);
        nxt();
        r_stb[2] = 1'b0;
        r_pack = 2'b01;
        r_pdi = 16'h0077;
        mid();
        chk("to_next_ack", r_ack, 3'b100);
        chk("to_next_rdata", r_cdo, 8'h77);
        nxt();
        r_pack = 2'b00;

        // Asynchronous reset with a read outstanding
        r_stb[2] = 1'b1;
        r_addr[32 +: 16] = 16'h9050;
        mid();
        chk("rstmid_pstb", r_pstb, 2'b10);
        nxt();
        r_stb[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", r_stall, 3'b111);
        chk("rstmid_ackerr", {r_ack, r_err}, 0);
        chk("rstmid_pstb0", r_pstb, 2'b00);
        chk("rstmid_pcyc", r_pcyc, 0);
        chk("rstmid_busy", r_busy, 0);
        chk("rstmid_owner", r_owner, 0);
        r_cyc = 3'b000;
        nxt();
        rst_n = 1'b1;
        r_pack = 2'b10;
        r_pdi = 16'hEE00;
        mid();
        chk("late_ack", r_ack, 3'b000);
        chk("late_busy", r_busy, 0);
        nxt();
        r_pack = 2'b00;
        mid();
        chk("late_busy2", r_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
